// File: rtl/cest_buff_ctrl.sv
// Pilot-buffer sequencer: fills the BRAM with one frame, then drains it in address
// order through a 2-entry skid FIFO that hides the 1-cycle BRAM read latency.
module cest_buff_ctrl #(
    parameter int unsigned DEPTH = 28,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          frame_done,
    output logic          bram_en,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_di,
    input  logic [DW-1:0] bram_dout
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] RD_END   = CW'(DEPTH);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [AW-1:0] pop_cnt;
    logic [DW-1:0] fifo0, fifo1;
    logic [1:0]    fifo_cnt;
    logic          rd_pend;

    logic valid_c, pop_c, accept_c, last_pop_c, issue_c;

    assign valid_c    = !rst && (fifo_cnt != 2'd0);
    assign pop_c      = valid_c && m_ready;
    assign accept_c   = !rst && (state == FILL) && s_valid;
    assign last_pop_c = pop_c && (pop_cnt == IDX_LAST);
    // Read only if the FIFO can still take it once the pending read lands.
    assign issue_c    = !rst && (state == DRAIN) && (rd_ptr < RD_END) &&
                        ((3'(fifo_cnt) + 3'(rd_pend)) <= (3'd1 + 3'(pop_c)));

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL:  if (accept_c && (wr_ptr == IDX_LAST)) state_nxt = DRAIN;
            DRAIN: if (last_pop_c)                       state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        s_ready   = 1'b0;
        m_valid   = valid_c;
        m_data    = fifo0;
        m_last    = valid_c && (pop_cnt == IDX_LAST);
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_di   = '0;
        if (!rst) begin
            unique case (state)
                FILL: begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        bram_en   = 1'b1;
                        bram_we   = 1'b1;
                        bram_addr = wr_ptr;
                        bram_di   = s_data;
                    end
                end
                DRAIN: begin
                    if (issue_c) begin
                        bram_en   = 1'b1;
                        bram_addr = AW'(rd_ptr);
                    end
                end
                default: ;
            endcase
        end
    end

    // Pointers, read pipeline and skid FIFO (fifo0 is the head).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pop_cnt    <= '0;
            fifo0      <= '0;
            fifo1      <= '0;
            fifo_cnt   <= '0;
            rd_pend    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_pop_c;
            rd_pend    <= issue_c;
            if (accept_c)
                wr_ptr <= (wr_ptr == IDX_LAST) ? '0 : wr_ptr + AW'(1);
            if (issue_c)
                rd_ptr <= rd_ptr + CW'(1);
            if (pop_c)
                pop_cnt <= pop_cnt + AW'(1);

            unique case ({rd_pend, pop_c})
                2'b10: begin
                    if (fifo_cnt == 2'd0) fifo0 <= bram_dout;
                    else                  fifo1 <= bram_dout;
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    fifo0    <= fifo1;
                    fifo_cnt <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        fifo0 <= bram_dout;
                    end else begin
                        fifo0 <= fifo1;
                        fifo1 <= bram_dout;
                    end
                end
                default: ;
            endcase

            if (last_pop_c) begin
                rd_ptr   <= '0;
                pop_cnt  <= '0;
                fifo_cnt <= '0;
                rd_pend  <= 1'b0;
            end
        end
    end

endmodule
